// File: rtl/dft_pkg.sv
// Shared constants, types and helpers for the DFT front-end blocks.
package dft_pkg;

  localparam logic ROUND_TRUNC = 1'b0;
  localparam logic ROUND_NEAR  = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } decim_state_e;

  // Accumulator must hold the sum of 2**max_log2_dec full-scale samples.
  function automatic int acc_w(input int data_w, input int max_log2_dec);
    return data_w + max_log2_dec;
  endfunction

endpackage

// File: rtl/dft_round_shift.sv
// Signed arithmetic right shift by a runtime amount, truncating toward zero or
// rounding to nearest with ties away from zero.
module dft_round_shift
  import dft_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 16,
  parameter int SH_W   = 3
) (
  input  logic [ACC_W-1:0]  sum_i,
  input  logic [SH_W-1:0]   shift_i,
  input  logic              round_i,
  output logic [DATA_W-1:0] res_o
);

  localparam int MAG_W = ACC_W + 1;

  logic             neg;
  logic [MAG_W-1:0] ext;
  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] bias;
  logic [MAG_W-1:0] scaled;
  logic [MAG_W-1:0] signed_res;

  // Work on the magnitude so both modes are symmetric about zero; one extra bit
  // keeps the magnitude of the most negative sum representable.
  always_comb begin
    neg  = sum_i[ACC_W-1];
    ext  = {sum_i[ACC_W-1], sum_i};
    if (neg) begin
      mag = MAG_W'(0) - ext;
    end else begin
      mag = ext;
    end
    if ((round_i == ROUND_NEAR) && (shift_i != SH_W'(0))) begin
      bias = MAG_W'(1) << (shift_i - SH_W'(1));
    end else begin
      bias = MAG_W'(0);
    end
    scaled = (mag + bias) >> shift_i;
    if (neg) begin
      signed_res = MAG_W'(0) - scaled;
    end else begin
      signed_res = scaled;
    end
    res_o = signed_res[DATA_W-1:0];
  end

endmodule

// File: rtl/dft_decim_avg.sv
// Block-averaging decimator: sums 2**L signed samples and emits their scaled mean
// through a single registered output slot with valid/ready flow control.
module dft_decim_avg
  import dft_pkg::*;
#(
  parameter int DATA_W       = 12,
  parameter int MAX_LOG2_DEC = 4,
  parameter int CFG_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CFG_W-1:0]  cfg_log2_dec,
  input  logic              cfg_round,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              sync_in,
  output logic              ready_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_out
);

  localparam int ACC_W = acc_w(DATA_W, MAX_LOG2_DEC);
  localparam int CNT_W = MAX_LOG2_DEC + 1;
  localparam logic [CFG_W-1:0] MAX_L = CFG_W'(MAX_LOG2_DEC);

  decim_state_e      state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CFG_W-1:0]  l_q, l_d;
  logic              round_q, round_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;

  logic              accept;
  logic              first;
  logic [CFG_W-1:0]  cfg_l_clamped;
  logic [CFG_W-1:0]  l_eff;
  logic              round_eff;
  logic [CNT_W-1:0]  cnt_base;
  logic [CNT_W-1:0]  last_cnt;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] rounded;

  assign ready_in  = !valid_out_q || ready_out;
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;

  dft_round_shift #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SH_W   (CFG_W)
  ) u_round_shift (
    .sum_i   (sum),
    .shift_i (l_eff),
    .round_i (round_eff),
    .res_o   (rounded)
  );

  // A block's first sample (idle, or sync) sees the live config and a zero base.
  always_comb begin
    accept = valid_in && ready_in;
    first  = (state_q == ST_IDLE) || sync_in;
    if (cfg_log2_dec > MAX_L) begin
      cfg_l_clamped = MAX_L;
    end else begin
      cfg_l_clamped = cfg_log2_dec;
    end
    if (first) begin
      l_eff     = cfg_l_clamped;
      round_eff = cfg_round;
      cnt_base  = CNT_W'(0);
      acc_base  = ACC_W'(0);
    end else begin
      l_eff     = l_q;
      round_eff = round_q;
      cnt_base  = cnt_q;
      acc_base  = acc_q;
    end
    last_cnt = (CNT_W'(1) << l_eff) - CNT_W'(1);
    sum      = acc_base + {{MAX_LOG2_DEC{data_in[DATA_W-1]}}, data_in};
  end

  // Next-state: accumulate, close blocks into the output slot, retire on handshake.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    l_d        = l_q;
    round_d    = round_q;
    data_out_d = data_out_q;
    if (valid_out_q && ready_out) begin
      valid_out_d = 1'b0;
    end else begin
      valid_out_d = valid_out_q;
    end
    if (accept) begin
      l_d     = l_eff;
      round_d = round_eff;
      if (cnt_base == last_cnt) begin
        data_out_d  = rounded;
        valid_out_d = 1'b1;
        acc_d       = ACC_W'(0);
        cnt_d       = CNT_W'(0);
        state_d     = ST_IDLE;
      end else begin
        acc_d   = sum;
        cnt_d   = cnt_base + CNT_W'(1);
        state_d = ST_ACCUM;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= ACC_W'(0);
      cnt_q       <= CNT_W'(0);
      l_q         <= CFG_W'(0);
      round_q     <= ROUND_TRUNC;
      data_out_q  <= DATA_W'(0);
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      l_q         <= l_d;
      round_q     <= round_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

endmodule

// File: tb/tb_dft_decim_avg.sv
// Self-checking bench for dft_decim_avg: directed vector table, hand-written
// flow-control/sync/reset sequences and a randomized run against an arithmetic model.
module tb_dft_decim_avg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  cfg_log2_dec = 3'd0;
  logic        cfg_round = 1'b0;
  logic [11:0] data_in = 12'd0;
  logic        valid_in = 1'b0;
  logic        sync_in = 1'b0;
  logic        ready_in;
  logic [11:0] data_out;
  logic        valid_out;
  logic        ready_out = 1'b1;

  int tests = 0;
  int fails = 0;
  int got_q[$];
  int exp_q[$];
  bit bp_en = 1'b0;

  typedef struct {
    int l;
    bit rnd;
    int a;
    int b;
    int expv;
  } vec_t;

  vec_t vecs[15];

  dft_decim_avg #(.DATA_W(12), .MAX_LOG2_DEC(4), .CFG_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_log2_dec (cfg_log2_dec),
    .cfg_round    (cfg_round),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .sync_in      (sync_in),
    .ready_in     (ready_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_out    (ready_out)
  );

  always #5 clk = ~clk;

  // Collect every output transfer (valid && ready seen before the edge).
  always @(negedge clk) begin
    if (rst && valid_out && ready_out) got_q.push_back(int'($signed(data_out)));
  end

  // Random downstream backpressure during the regression phase.
  always @(posedge clk) begin
    #1;
    if (bp_en) ready_out = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Rule-level reference: mean of a block of 2**l samples.
  function automatic int model_avg(input int s, input int l, input bit r);
    int m;
    int q;
    if (!r || l == 0) return s / (1 << l);
    m = (s < 0) ? -s : s;
    q = (m + (1 << (l - 1))) >> l;
    return (s < 0) ? -q : q;
  endfunction

  // Called at posedge+1; holds the sample until accepted, returns at posedge+1.
  task automatic send(input int d, input bit sync);
    bit ok;
    int tries;
    ok = 1'b0;
    tries = 0;
    valid_in = 1'b1;
    sync_in = sync;
    data_in = 12'(d);
    while (!ok && tries < 1000) begin
      @(negedge clk);
      ok = ready_in;
      @(posedge clk);
      #1;
      tries++;
    end
    valid_in = 1'b0;
    sync_in = 1'b0;
    if (!ok) chk("send_accept", int'(ok), 1);
  endtask

  task automatic check_q(input string name);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk(name, got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int l, input bit r);
    cfg_log2_dec = 3'(l);
    cfg_round = r;
  endtask

  initial begin
    int l, le, n, cnt, s, d;
    bit r, abort, pend_sync;

    vecs[0]  = '{1, 1'b0, 5, -2, 1};
    vecs[1]  = '{1, 1'b0, -3, 0, -1};
    vecs[2]  = '{1, 1'b0, 2047, 2046, 2046};
    vecs[3]  = '{1, 1'b1, -3, 0, -2};
    vecs[4]  = '{1, 1'b1, 5, -2, 2};
    vecs[5]  = '{4, 1'b0, 2047, 2047, 2047};
    vecs[6]  = '{4, 1'b0, -2048, -2048, -2048};
    vecs[7]  = '{4, 1'b1, 2047, 2047, 2047};
    vecs[8]  = '{4, 1'b1, -2048, -2048, -2048};
    vecs[9]  = '{7, 1'b0, 100, 200, 150};
    vecs[10] = '{3, 1'b1, 1, 2, 2};
    vecs[11] = '{3, 1'b0, 1, 2, 1};
    vecs[12] = '{3, 1'b1, -1, -2, -2};
    vecs[13] = '{2, 1'b1, -1, -2, -2};
    vecs[14] = '{2, 1'b0, -1, -2, -1};

    #12;
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_ready_in", int'(ready_in), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed block averages; first half of each block is a, second half b.
    for (int v = 0; v < 15; v++) begin
      set_cfg(vecs[v].l, vecs[v].rnd);
      le = (vecs[v].l > 4) ? 4 : vecs[v].l;
      n = 1 << le;
      for (int k = 0; k < n; k++) send((k < n / 2) ? vecs[v].a : vecs[v].b, 1'b0);
      exp_q.push_back(vecs[v].expv);
      check_q($sformatf("vec%0d", v));
    end

    // L=0 passthrough, one per cycle, result visible right after the accepting edge.
    set_cfg(0, 1'b1);
    send(7, 1'b0);
    chk("l0_lat_data0", int'($signed(data_out)), 7);
    send(-9, 1'b0);
    chk("l0_lat_data1", int'($signed(data_out)), -9);
    chk("l0_lat_valid", int'(valid_out), 1);
    send(3, 1'b0);
    chk("l0_lat_data2", int'($signed(data_out)), 3);
    exp_q = '{7, -9, 3};
    check_q("l0_pass");

    // Backpressure with the next sample held at the input.
    ready_out = 1'b0;
    send(11, 1'b0);
    valid_in = 1'b1;
    data_in = 12'd12;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid_hold", int'(valid_out), 1);
      chk("bp_data_hold", int'($signed(data_out)), 11);
      chk("bp_ready_in", int'(ready_in), 0);
      @(posedge clk);
      #1;
    end
    ready_out = 1'b1;
    for (int k = 12; k <= 16; k++) send(k, 1'b0);
    exp_q = '{11, 12, 13, 14, 15, 16};
    check_q("bp_order");

    // Config change mid-block applies only to the following block.
    set_cfg(2, 1'b0);
    send(1, 1'b0);
    send(2, 1'b0);
    set_cfg(1, 1'b0);
    send(3, 1'b0);
    send(4, 1'b0);
    send(5, 1'b0);
    send(7, 1'b0);
    exp_q = '{2, 6};
    check_q("cfg_change");

    // sync_in discards a partial block.
    set_cfg(2, 1'b0);
    send(1, 1'b0);
    send(2, 1'b0);
    send(9, 1'b1);
    send(9, 1'b0);
    send(9, 1'b0);
    send(9, 1'b0);
    exp_q = '{9};
    check_q("sync");

    // Async reset drops a pending output, then drops a partial block.
    set_cfg(1, 1'b0);
    ready_out = 1'b0;
    send(40, 1'b0);
    send(60, 1'b0);
    chk("pend_data", int'($signed(data_out)), 50);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid_out", int'(valid_out), 0);
    chk("arst_data_out", int'(data_out), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    ready_out = 1'b1;
    @(posedge clk);
    #1;
    send(77, 1'b0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(10, 1'b0);
    send(20, 1'b0);
    exp_q = '{15};
    check_q("arst_fresh");

    // Randomized regression with backpressure, gaps, aborted blocks and config churn.
    bp_en = 1'b1;
    pend_sync = 1'b0;
    for (int b = 0; b < 1000; b++) begin
      l = $urandom_range(0, 5);
      if (l == 5) l = $urandom_range(5, 7);
      r = 1'($urandom_range(0, 1));
      le = (l > 4) ? 4 : l;
      n = 1 << le;
      abort = (le > 0) && ($urandom_range(0, 9) == 0);
      cnt = abort ? $urandom_range(1, n - 1) : n;
      s = 0;
      set_cfg(l, r);
      for (int k = 0; k < cnt; k++) begin
        d = int'($urandom_range(0, 4095)) - 2048;
        send(d, (k == 0) && (pend_sync || ($urandom_range(0, 7) == 0)));
        s += d;
        if (k == 0) set_cfg($urandom_range(0, 7), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 7) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      pend_sync = abort;
      if (!abort) exp_q.push_back(model_avg(s, le, r));
      check_q("rand");
    end
    bp_en = 1'b0;
    @(posedge clk);
    #2;
    ready_out = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_q("final_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
